top_k_stream_sorter: RTL
========================

TOP_K_STREAM_SORTER -- requirements
Module: top_k_stream_sorter

Interface
REQ-001 SHALL have parameter TOP_K_NUM, default 16, meaning number of retained largest values (2..64).
REQ-002 SHALL have parameter INTEGER_SIZE, default 32, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous frame abort.
REQ-006 SHALL have port rx_data_TDATA  input  INTEGER_SIZE  input element.
REQ-007 SHALL have port rx_data_TVALID  input  1  input element valid.
REQ-008 SHALL have port rx_data_TLAST  input  1  last element of frame.
REQ-009 SHALL have port rx_data_TREADY  output  1  element accepted when high with TVALID.
REQ-010 SHALL have port tx_data_TDATA  output  TOP_K_NUM*INTEGER_SIZE  packed result; slot 0 (largest) in bits [INTEGER_SIZE-1:0].
REQ-011 SHALL have port tx_data_TKEEP  output  TOP_K_NUM  per-slot occupied flag.
REQ-012 SHALL have port tx_data_TVALID  output  1  result valid.
REQ-013 SHALL have port tx_data_TREADY  input  1  downstream accepts result.

Function
REQ-014 SHALL implement states COLLECT and OUTPUT; COLLECT is the reset state.
REQ-015 In COLLECT, rx_data_TREADY SHALL be 1; in OUTPUT it SHALL be 0.
REQ-016 Each accepted element SHALL be inserted in one cycle into a descending-sorted slot array; smaller slots shift down one position and slot TOP_K_NUM-1 is discarded.
REQ-017 An element SHALL be inserted only if a slot is empty or it is strictly greater than slot TOP_K_NUM-1; on ties, the new element SHALL be placed after existing equal values.
REQ-018 Sustained throughput SHALL be one element per cycle with no bubbles.
REQ-019 Accepting an element with TLAST=1 SHALL insert it and move to OUTPUT on the same edge; tx_data_TVALID SHALL be 1 in the following cycle (latency 1).
REQ-020 In OUTPUT, tx_data_TDATA, tx_data_TKEEP and tx_data_TVALID SHALL be held stable until tx_data_TREADY=1.
REQ-021 On the OUTPUT handshake, all slots SHALL be emptied and the state SHALL return to COLLECT; a new frame SHALL be accepted in the next cycle.
REQ-022 Empty slots SHALL read 0 in tx_data_TDATA with TKEEP bit 0; a frame shorter than TOP_K_NUM SHALL yield TKEEP with the low-order count bits set.
REQ-023 clear=1 SHALL empty all slots, force COLLECT and drop any pending result; clear SHALL take priority over a simultaneous rx or tx handshake.
REQ-024 A single-element frame (TLAST on the first beat) SHALL produce a result with TKEEP=1.
REQ-025 tx_data_TVALID SHALL be 0 whenever the state is COLLECT.

Reset
REQ-026 rst_n=0 SHALL asynchronously force COLLECT, all slots empty, tx_data_TVALID=0, tx_data_TKEEP=0 and tx_data_TDATA=0; rx_data_TREADY SHALL be 1 after release.
REQ-027 Reset asserted mid-frame or mid-OUTPUT SHALL discard all partial results without emitting them.

Configuration
REQ-028 With macro TOP_K_SIGNED_EN defined, all comparisons SHALL be two's-complement signed; without it, comparisons SHALL be unsigned.

Structure
REQ-029 Package top_k_pkg SHALL hold the state enumeration and the slot-index width localparam $clog2(TOP_K_NUM).
REQ-030 Per-slot compare/shift logic SHALL be a sub-module top_k_slot (value and occupied registers, compare-with-input, load-from-input and load-from-upper-neighbour controls).

Verification
REQ-031 Input stream 5,9,1,7 (TLAST on 7) with TOP_K_NUM=4 -> TDATA slots 9,7,5,1 and TKEEP=4'b1111, TVALID one cycle after the TLAST beat.
REQ-032 Input stream 1..20 with TOP_K_NUM=16 -> slots 20 down to 5 and TKEEP all ones; 1..4 discarded.
REQ-033 Three-element frame 3,3,2 with TOP_K_NUM=16 -> slots 3,3,2,0... and TKEEP=16'h0007.
REQ-034 Result pending with TREADY held 0 for 10 cycles, then pulsed -> TDATA stable, rx_data_TREADY=0 throughout, and the next frame accepted one cycle after the pulse.
REQ-035 clear asserted mid-frame after 5,6, followed by a new frame 1 with TLAST -> result has slot 0=1 and TKEEP=1; 5 and 6 are absent.
REQ-036 Frame 0xFFFFFFFF,0x00000001 -> unsigned build gives slots 0xFFFFFFFF,1; TOP_K_SIGNED_EN build gives slots 1,0xFFFFFFFF.

Source files
------------

// File: rtl/top_k_pkg.sv
// Shared definitions for the top-K stream sorter.
//   state_e       : controller states; COLLECT is the reset state.
//   SLOT_IDX_W    : slot-index width for the default TOP_K_NUM.
//   slot_idx_w()  : slot-index width for any TOP_K_NUM (never below 1).
package top_k_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    localparam int DEF_TOP_K_NUM = 16;
    localparam int SLOT_IDX_W    = $clog2(DEF_TOP_K_NUM);

    function automatic int slot_idx_w(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/top_k_stream_sorter_if.sv
// Stream bundle for the top-K sorter: input element stream (rx_*) and
// packed result stream (tx_*).
//   master : the side that sources rx elements and sinks tx results
//   slave  : the sorter side
interface top_k_stream_sorter_if #(
    parameter int TOP_K_NUM    = 16,
    parameter int INTEGER_SIZE = 32
);
    logic [INTEGER_SIZE-1:0]           rx_tdata;
    logic                              rx_tvalid;
    logic                              rx_tlast;
    logic                              rx_tready;
    logic [TOP_K_NUM*INTEGER_SIZE-1:0] tx_tdata;
    logic [TOP_K_NUM-1:0]              tx_tkeep;
    logic                              tx_tvalid;
    logic                              tx_tready;

    modport master (
        output rx_tdata, rx_tvalid, rx_tlast, tx_tready,
        input  rx_tready, tx_tdata, tx_tkeep, tx_tvalid
    );

    modport slave (
        input  rx_tdata, rx_tvalid, rx_tlast, tx_tready,
        output rx_tready, tx_tdata, tx_tkeep, tx_tvalid
    );
endinterface

// File: rtl/top_k_slot.sv
// One position of the descending-sorted slot array.
// Config macro: TOP_K_SIGNED_EN selects signed comparison (unsigned default).
//   clk, rst_n        : clock, async active-low reset
//   clr               : synchronous empty
//   in_vld, in_data   : element being inserted this cycle
//   upper_gt          : neighbour above also wants the element (shift from it)
//   upper_val/occ     : neighbour above's current contents
//   gt                : this slot is empty or strictly smaller than in_data
//   val, occ          : slot contents
module top_k_slot
    import top_k_pkg::*;
#(
    parameter int INTEGER_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic [INTEGER_SIZE-1:0] in_data,
    input  logic                    upper_gt,
    input  logic [INTEGER_SIZE-1:0] upper_val,
    input  logic                    upper_occ,
    output logic                    gt,
    output logic [INTEGER_SIZE-1:0] val,
    output logic                    occ
);
    logic [INTEGER_SIZE-1:0] val_q, val_d;
    logic                    occ_q, occ_d;
    logic                    in_gt;

`ifdef TOP_K_SIGNED_EN
    assign in_gt = $signed(in_data) > $signed(val_q);
`else
    assign in_gt = in_data > val_q;
`endif

    // Strict compare keeps a new tie below existing equal values.
    assign gt = ~occ_q | in_gt;

    always_comb begin
        val_d = val_q;
        occ_d = occ_q;
        if (clr) begin
            val_d = '0;
            occ_d = 1'b0;
        end else if (in_vld && gt) begin
            // gt is monotone down the array: the first gt slot takes the
            // element, every slot below it takes its upper neighbour.
            if (upper_gt) begin
                val_d = upper_val;
                occ_d = upper_occ;
            end else begin
                val_d = in_data;
                occ_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            occ_q <= 1'b0;
        end else begin
            val_q <= val_d;
            occ_q <= occ_d;
        end
    end

    assign val = val_q;
    assign occ = occ_q;

endmodule

// File: rtl/top_k_stream_sorter.sv
// Keeps the TOP_K_NUM largest elements of each TLAST-delimited frame and
// emits them as one packed, descending-sorted result (slot 0 in the low bits).
// Config macro: TOP_K_SIGNED_EN selects signed comparison (unsigned default).
//   clk, rst_n         : clock, async active-low reset
//   clear              : synchronous frame abort, overrides both handshakes
//   rx_data_*          : element input stream, one element per cycle
//   tx_data_TDATA/KEEP : packed result and per-slot occupied flags
//   tx_data_TVALID/RDY : result handshake; result held until accepted
module top_k_stream_sorter
    import top_k_pkg::*;
#(
    parameter int TOP_K_NUM    = 16,
    parameter int INTEGER_SIZE = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [INTEGER_SIZE-1:0]           rx_data_TDATA,
    input  logic                              rx_data_TVALID,
    input  logic                              rx_data_TLAST,
    output logic                              rx_data_TREADY,
    output logic [TOP_K_NUM*INTEGER_SIZE-1:0] tx_data_TDATA,
    output logic [TOP_K_NUM-1:0]              tx_data_TKEEP,
    output logic                              tx_data_TVALID,
    input  logic                              tx_data_TREADY
);
    state_e state_q, state_d;
    logic   tvalid_q, tvalid_d;
    logic   tready_q, tready_d;

    logic [TOP_K_NUM-1:0][INTEGER_SIZE-1:0] slot_val;
    logic [TOP_K_NUM-1:0]                   slot_occ;
    logic [TOP_K_NUM-1:0]                   slot_gt;

    logic rx_acc, tx_hs, slot_clr;

    assign rx_acc   = rx_data_TVALID & tready_q;
    assign tx_hs    = tvalid_q & tx_data_TREADY;
    assign slot_clr = clear | tx_hs;

    for (genvar i = 0; i < TOP_K_NUM; i++) begin : g_slot
        logic                    up_gt;
        logic [INTEGER_SIZE-1:0] up_val;
        logic                    up_occ;
        if (i == 0) begin : g_head
            assign up_gt  = 1'b0;
            assign up_val = '0;
            assign up_occ = 1'b0;
        end else begin : g_body
            assign up_gt  = slot_gt[i-1];
            assign up_val = slot_val[i-1];
            assign up_occ = slot_occ[i-1];
        end

        top_k_slot #(.INTEGER_SIZE(INTEGER_SIZE)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (slot_clr),
            .in_vld    (rx_acc),
            .in_data   (rx_data_TDATA),
            .upper_gt  (up_gt),
            .upper_val (up_val),
            .upper_occ (up_occ),
            .gt        (slot_gt[i]),
            .val       (slot_val[i]),
            .occ       (slot_occ[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tready_d = tready_q;
        if (clear) begin
            state_d  = COLLECT;
            tvalid_d = 1'b0;
            tready_d = 1'b1;
        end else begin
            case (state_q)
                COLLECT: if (rx_acc && rx_data_TLAST) begin
                    state_d  = OUTPUT;
                    tvalid_d = 1'b1;
                    tready_d = 1'b0;
                end
                OUTPUT: if (tx_hs) begin
                    state_d  = COLLECT;
                    tvalid_d = 1'b0;
                    tready_d = 1'b1;
                end
                default: begin
                    state_d  = COLLECT;
                    tvalid_d = 1'b0;
                    tready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            tvalid_q <= 1'b0;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tready_q <= tready_d;
        end
    end

    // Slots are frozen in OUTPUT (no rx accept), so the result is stable
    // straight from the slot registers; empty slots already hold zero.
    assign rx_data_TREADY = tready_q;
    assign tx_data_TVALID = tvalid_q;
    assign tx_data_TDATA  = slot_val;
    assign tx_data_TKEEP  = slot_occ;

endmodule
